fifo_read_checker: RTL and testbench

Single-clock read-side agent for the async FIFO bench. It pops the FIFO whenever data is available and checks each popped byte against a locally regenerated expected sequence (incrementing or LFSR). It reports pass/fail, a word count, an error count and first-error capture. It sits on the read_clk domain of the FIFO, at the opposite end from the write-side stimulus.

---
 rtl/fifo_bench_pkg.sv | 34 +++
 rtl/fifo_pattern_gen.sv | 44 ++++
 rtl/fifo_read_checker.sv | 152 +++++++++++++++
 tb/tb_fifo_read_checker.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_bench_pkg.sv
// Shared types and pattern helpers for the async FIFO bench agents.
package fifo_bench_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int PAT_INCR = 0;
  localparam int PAT_LFSR = 1;

  localparam logic [7:0] LFSR_POLY_8 = 8'hB8;

  // Right-shifting Galois LFSR feedback taps for common data widths.
  function automatic logic [31:0] lfsr_poly(input int width);
    case (width)
      4:       lfsr_poly = 32'h0000_000C;
      5:       lfsr_poly = 32'h0000_0014;
      6:       lfsr_poly = 32'h0000_0030;
      7:       lfsr_poly = 32'h0000_0060;
      16:      lfsr_poly = 32'h0000_B400;
      default: lfsr_poly = {24'h0, LFSR_POLY_8};
    endcase
  endfunction

  // Next value of the 8-bit reference sequence (increment or Galois LFSR).
  function automatic logic [7:0] next_pattern(input int mode, input logic [7:0] value);
    if (mode == PAT_LFSR) next_pattern = (value >> 1) ^ (value[0] ? LFSR_POLY_8 : 8'h00);
    else                  next_pattern = value + 8'd1;
  endfunction

endpackage

// File: rtl/fifo_pattern_gen.sv
// Loadable, enable-advanced pattern generator. Used on both the write and
// read side of the FIFO bench so the two ends walk identical sequences.
module fifo_pattern_gen
  import fifo_bench_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                PAT_MODE = PAT_INCR,
  parameter logic [DATA_W-1:0] SEED     = DATA_W'(1)
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              load,
  input  logic              advance,
  output logic [DATA_W-1:0] value
);

  // An LFSR never leaves the all-zero state, so a zero seed becomes 1.
  localparam logic [DATA_W-1:0] START =
    (PAT_MODE == PAT_LFSR && SEED == '0) ? DATA_W'(1) : SEED;
  localparam logic [DATA_W-1:0] POLY = DATA_W'(lfsr_poly(DATA_W));

  logic [DATA_W-1:0] next_value;

  generate
    if (DATA_W == 8) begin : g_w8
      // 8-bit case uses the shared reference step function.
      always_comb next_value = next_pattern(PAT_MODE, value);
    end else begin : g_wn
      // Other widths use the same step rule with width-specific taps.
      always_comb begin
        if (PAT_MODE == PAT_LFSR) next_value = (value >> 1) ^ (value[0] ? POLY : '0);
        else                      next_value = value + DATA_W'(1);
      end
    end
  endgenerate

  // Load has priority over advance so a restart always begins at the seed.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)       value <= START;
    else if (load)    value <= START;
    else if (advance) value <= next_value;
  end

endmodule

// File: rtl/fifo_read_checker.sv
// Read-side FIFO bench agent: pops the FIFO while data is available,
// compares each returned word against a regenerated expected stream and
// reports counts, pass/fail and the first mismatch.
//
// Handshake: read_en is a pop request seen by the FIFO on the rising edge of
// clk; it is only raised while mem_empty is low, and the popped word is taken
// to be valid on read_data exactly READ_LATENCY cycles later.
module fifo_read_checker
  import fifo_bench_pkg::*;
#(
  parameter int                DATA_W       = 8,
  parameter int                NUM_WORDS    = 256,
  parameter int                READ_LATENCY = 1,
  parameter int                PAT_MODE     = PAT_INCR,
  parameter logic [DATA_W-1:0] SEED         = DATA_W'(1),
  parameter logic [7:0]        THROTTLE     = 8'hFF,
  localparam int               CW           = $clog2(NUM_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              start,
  input  logic              mem_empty,
  input  logic [DATA_W-1:0] read_data,
  output logic              read_en,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CW-1:0]     rx_count,
  output logic [CW-1:0]     err_count,
  output logic [CW-1:0]     first_err_idx,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got,
  output state_t            state_dbg
);

  // Marks the pipe slot whose word is on read_data this cycle.
  localparam logic [READ_LATENCY-1:0] HEAD = READ_LATENCY'(1) << (READ_LATENCY - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [CW-1:0]           issued;
  logic [2:0]              idx;
  logic [READ_LATENCY-1:0] pipe;
  logic [DATA_W-1:0]       expected;
  logic                    start_ok;
  logic                    last_issue;
  logic                    in_flight;
  logic                    word_valid;
  logic                    mismatch;

  assign state_dbg  = state;
  assign start_ok   = start && (state == IDLE || state == DONE);
  assign last_issue = read_en && (issued == CW'(NUM_WORDS - 1));
  // Reads still travelling other than the one retiring this cycle.
  assign in_flight  = |(pipe & ~HEAD);
  assign word_valid = pipe[READ_LATENCY-1];
  assign mismatch   = word_valid && (read_data != expected);
  assign pass       = done && (err_count == '0) && (rx_count == CW'(NUM_WORDS));

  // State register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start is only honoured from IDLE or DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start)      state_nxt = RUN;
      RUN:        if (last_issue) state_nxt = DRAIN;
      DRAIN:      if (!in_flight) state_nxt = DONE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // State outputs; pops only when data exists, budget remains and the mask allows.
  always_comb begin
    read_en = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      RUN: begin
        busy    = 1'b1;
        read_en = ~mem_empty & (issued < CW'(NUM_WORDS)) & THROTTLE[idx];
      end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Issue count and throttle slot, both restarted by an accepted start.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      issued <= '0;
      idx    <= '0;
    end else if (start_ok) begin
      issued <= '0;
      idx    <= '0;
    end else if (state == RUN) begin
      idx <= idx + 3'd1;
      if (read_en) issued <= issued + CW'(1);
    end
  end

  // Latency pipe: one bit per outstanding pop, head bit means data valid now.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) pipe <= '0;
    else        pipe <= (pipe << 1) | READ_LATENCY'(read_en);
  end

  // Result counters and first-mismatch capture.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rx_count      <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else if (start_ok) begin
      rx_count      <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else if (word_valid) begin
      rx_count <= rx_count + CW'(1);
      if (mismatch) begin
        if (err_count != '1) err_count <= err_count + CW'(1);
        if (err_count == '0) begin
          first_err_idx <= rx_count;
          first_err_exp <= expected;
          first_err_got <= read_data;
        end
      end
    end
  end

  fifo_pattern_gen #(
    .DATA_W   (DATA_W),
    .PAT_MODE (PAT_MODE),
    .SEED     (SEED)
  ) u_pattern (
    .clk     (clk),
    .rst_l   (rst_l),
    .load    (start_ok),
    .advance (word_valid),
    .value   (expected)
  );

endmodule

// File: tb/tb_fifo_read_checker.sv
// Directed bench for fifo_read_checker: four configurations share one clock
// and a behavioural FIFO read port model each.
//   0: 16 words, incrementing from 0x01, latency 1, no throttle
//   1: 256 words, LFSR from 0x01
//   2: 2 words, incrementing from 0xFF (wrap)
//   3: 16 words, latency 3, throttle 0x55
module tb_fifo_read_checker;
  import fifo_bench_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_l;

  logic       start     [N];
  logic       block     [N];
  logic       rewind    [N];
  logic       read_en   [N];
  logic       mem_empty [N];
  logic       busy      [N];
  logic       done_v    [N];
  logic       pass_v    [N];
  logic [7:0] read_data [N];
  logic [7:0] fexp      [N];
  logic [7:0] fgot      [N];
  state_t     st        [N];

  logic [4:0] a_rx, a_err, a_fidx;
  logic [8:0] b_rx, b_err, b_fidx;
  logic [1:0] c_rx, c_err, c_fidx;
  logic [4:0] d_rx, d_err, d_fidx;

  logic [7:0] mem [N][256];
  int         len [N];
  int         rd  [N];
  logic [7:0] dp  [N][3];

  int errors = 0;
  int checks = 0;

  // Clock.
  always #5 clk = ~clk;

  // FIFO read port models: pop on read_en, data appears after the latency.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rewind[i])       rd[i] <= 0;
      else if (read_en[i]) rd[i] <= rd[i] + 1;
      dp[i][2] <= dp[i][1];
      dp[i][1] <= dp[i][0];
      dp[i][0] <= read_en[i] ? mem[i][rd[i][7:0]] : 8'hEE;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_empty
    assign mem_empty[g] = (rd[g] >= len[g]) || block[g];
  end

  assign read_data[0] = dp[0][0];
  assign read_data[1] = dp[1][0];
  assign read_data[2] = dp[2][0];
  assign read_data[3] = dp[3][2];

  fifo_read_checker #(.NUM_WORDS(16), .READ_LATENCY(1), .PAT_MODE(0), .SEED(8'h01), .THROTTLE(8'hFF)) u_inc (
    .clk(clk), .rst_l(rst_l), .start(start[0]), .mem_empty(mem_empty[0]), .read_data(read_data[0]),
    .read_en(read_en[0]), .busy(busy[0]), .done(done_v[0]), .pass(pass_v[0]), .rx_count(a_rx),
    .err_count(a_err), .first_err_idx(a_fidx), .first_err_exp(fexp[0]), .first_err_got(fgot[0]),
    .state_dbg(st[0]));

  fifo_read_checker #(.NUM_WORDS(256), .READ_LATENCY(1), .PAT_MODE(1), .SEED(8'h01), .THROTTLE(8'hFF)) u_lfsr (
    .clk(clk), .rst_l(rst_l), .start(start[1]), .mem_empty(mem_empty[1]), .read_data(read_data[1]),
    .read_en(read_en[1]), .busy(busy[1]), .done(done_v[1]), .pass(pass_v[1]), .rx_count(b_rx),
    .err_count(b_err), .first_err_idx(b_fidx), .first_err_exp(fexp[1]), .first_err_got(fgot[1]),
    .state_dbg(st[1]));

  fifo_read_checker #(.NUM_WORDS(2), .READ_LATENCY(1), .PAT_MODE(0), .SEED(8'hFF), .THROTTLE(8'hFF)) u_wrap (
    .clk(clk), .rst_l(rst_l), .start(start[2]), .mem_empty(mem_empty[2]), .read_data(read_data[2]),
    .read_en(read_en[2]), .busy(busy[2]), .done(done_v[2]), .pass(pass_v[2]), .rx_count(c_rx),
    .err_count(c_err), .first_err_idx(c_fidx), .first_err_exp(fexp[2]), .first_err_got(fgot[2]),
    .state_dbg(st[2]));

  fifo_read_checker #(.NUM_WORDS(16), .READ_LATENCY(3), .PAT_MODE(0), .SEED(8'h01), .THROTTLE(8'h55)) u_thr (
    .clk(clk), .rst_l(rst_l), .start(start[3]), .mem_empty(mem_empty[3]), .read_data(read_data[3]),
    .read_en(read_en[3]), .busy(busy[3]), .done(done_v[3]), .pass(pass_v[3]), .rx_count(d_rx),
    .err_count(d_err), .first_err_idx(d_fidx), .first_err_exp(fexp[3]), .first_err_got(fgot[3]),
    .state_dbg(st[3]));

  // ---------------- driver tasks (called at a falling edge) ----------------

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic load_incr(input int i, input int n, input logic [7:0] first);
    logic [7:0] v;
    v = first;
    for (int k = 0; k < n; k++) begin
      mem[i][k] = v;
      v = v + 8'd1;
    end
    len[i]    = n;
    rewind[i] = 1'b1;
    @(negedge clk);
    rewind[i] = 1'b0;
  endtask

  task automatic rewind_fifo(input int i);
    rewind[i] = 1'b1;
    @(negedge clk);
    rewind[i] = 1'b0;
  endtask

  // Runs until done; optionally toggles the FIFO empty override every 3 cycles.
  // Counts pops, DRAIN cycles and pops that violate empty or the throttle mask.
  task automatic run_until_done(input int i, input int budget, input bit toggle, input logic [7:0] mask,
                                output int pulses, output int drain, output int viol);
    bit ok;
    pulses = 0; drain = 0; viol = 0; ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (toggle && k > 0 && (k % 3) == 0) block[i] = ~block[i];
      #1;
      if (done_v[i]) begin ok = 1'b1; break; end
      if (read_en[i]) begin
        pulses++;
        if (mem_empty[i] || !mask[k % 8]) viol++;
      end
      if (st[i] == DRAIN) drain++;
      @(negedge clk);
    end
    block[i] = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL run_timeout inst=%0d got done=0 need done=1 within %0d cycles", i, budget); end
  endtask

  // ---------------- tests ----------------

  task automatic test_reset();
    rst_l = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (read_en[0] !== 1'b0) begin errors++; $display("FAIL rst_read_en got=%b exp=0", read_en[0]); end
    checks++; if (busy[0] !== 1'b0)    begin errors++; $display("FAIL rst_busy got=%b exp=0", busy[0]); end
    checks++; if (done_v[0] !== 1'b0)  begin errors++; $display("FAIL rst_done got=%b exp=0", done_v[0]); end
    checks++; if (pass_v[0] !== 1'b0)  begin errors++; $display("FAIL rst_pass got=%b exp=0", pass_v[0]); end
    checks++; if (a_rx !== 5'd0)       begin errors++; $display("FAIL rst_rx got=%0d exp=0", a_rx); end
    checks++; if (a_err !== 5'd0)      begin errors++; $display("FAIL rst_err got=%0d exp=0", a_err); end
    checks++; if (a_fidx !== 5'd0 || fexp[0] !== 8'h00 || fgot[0] !== 8'h00) begin
      errors++; $display("FAIL rst_capture got=%0d/%h/%h exp=0/00/00", a_fidx, fexp[0], fgot[0]); end
    checks++; if (st[0] !== IDLE)      begin errors++; $display("FAIL rst_state got=%0d exp=%0d", st[0], IDLE); end
    checks++; if (pass_v[1] !== 1'b0 || done_v[3] !== 1'b0) begin
      errors++; $display("FAIL rst_other got pass1=%b done3=%b exp 0/0", pass_v[1], done_v[3]); end
    rst_l = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int p, d, v;
    load_incr(0, 16, 8'h01);
    pulse_start(0);
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy[0]); end
    run_until_done(0, 100, 1'b0, 8'hFF, p, d, v);
    checks++; if (p != 16)           begin errors++; $display("FAIL basic_pulses got=%0d exp=16", p); end
    checks++; if (d != 1)            begin errors++; $display("FAIL basic_drain got=%0d exp=1", d); end
    checks++; if (pass_v[0] !== 1'b1) begin errors++; $display("FAIL basic_pass got=%b exp=1", pass_v[0]); end
    checks++; if (a_rx !== 5'd16)    begin errors++; $display("FAIL basic_rx got=%0d exp=16", a_rx); end
    checks++; if (a_err !== 5'd0)    begin errors++; $display("FAIL basic_err got=%0d exp=0", a_err); end
    checks++; if (busy[0] !== 1'b0)  begin errors++; $display("FAIL basic_busy_done got=%b exp=0", busy[0]); end
  endtask

  task automatic test_corrupt();
    int p, d, v;
    load_incr(0, 16, 8'h01);
    mem[0][5] = 8'hAA;
    pulse_start(0);
    run_until_done(0, 100, 1'b0, 8'hFF, p, d, v);
    checks++; if (a_err !== 5'd1)     begin errors++; $display("FAIL corrupt_err got=%0d exp=1", a_err); end
    checks++; if (a_fidx !== 5'd5)    begin errors++; $display("FAIL corrupt_idx got=%0d exp=5", a_fidx); end
    checks++; if (fexp[0] !== 8'h06)  begin errors++; $display("FAIL corrupt_exp got=%h exp=06", fexp[0]); end
    checks++; if (fgot[0] !== 8'hAA)  begin errors++; $display("FAIL corrupt_got got=%h exp=aa", fgot[0]); end
    checks++; if (pass_v[0] !== 1'b0) begin errors++; $display("FAIL corrupt_pass got=%b exp=0", pass_v[0]); end
    checks++; if (a_rx !== 5'd16)     begin errors++; $display("FAIL corrupt_rx got=%0d exp=16", a_rx); end
  endtask

  task automatic test_back_to_back();
    int p, d, v;
    load_incr(0, 16, 8'h01);
    pulse_start(0);
    checks++; if (a_err !== 5'd0 || a_rx !== 5'd0 || a_fidx !== 5'd0) begin
      errors++; $display("FAIL b2b_clear got err=%0d rx=%0d idx=%0d exp 0/0/0", a_err, a_rx, a_fidx); end
    checks++; if (done_v[0] !== 1'b0) begin errors++; $display("FAIL b2b_done got=%b exp=0", done_v[0]); end
    run_until_done(0, 100, 1'b0, 8'hFF, p, d, v);
    checks++; if (pass_v[0] !== 1'b1 || a_rx !== 5'd16) begin
      errors++; $display("FAIL b2b_pass got pass=%b rx=%0d exp 1/16", pass_v[0], a_rx); end
  endtask

  task automatic test_start_ignored();
    int p, d, v;
    load_incr(0, 16, 8'h01);
    pulse_start(0);
    for (int c = 0; c < 50 && a_rx != 5'd4; c++) @(negedge clk);
    checks++; if (a_rx !== 5'd4) begin errors++; $display("FAIL ign_reach got=%0d exp=4", a_rx); end
    pulse_start(0);
    checks++; if (a_rx !== 5'd5 || busy[0] !== 1'b1) begin
      errors++; $display("FAIL ign_continue got rx=%0d busy=%b exp 5/1", a_rx, busy[0]); end
    run_until_done(0, 100, 1'b0, 8'hFF, p, d, v);
    checks++; if (pass_v[0] !== 1'b1 || a_rx !== 5'd16) begin
      errors++; $display("FAIL ign_pass got pass=%b rx=%0d exp 1/16", pass_v[0], a_rx); end
  endtask

  task automatic test_reset_mid();
    int p, d, v;
    load_incr(0, 16, 8'h01);
    pulse_start(0);
    for (int c = 0; c < 50 && a_rx != 5'd7; c++) @(negedge clk);
    checks++; if (a_rx !== 5'd7 || read_en[0] !== 1'b1) begin
      errors++; $display("FAIL mid_reach got rx=%0d read_en=%b exp 7/1", a_rx, read_en[0]); end
    rst_l = 1'b0;
    #1;
    checks++; if (read_en[0] !== 1'b0) begin errors++; $display("FAIL mid_read_en got=%b exp=0", read_en[0]); end
    checks++; if (busy[0] !== 1'b0 || done_v[0] !== 1'b0 || pass_v[0] !== 1'b0) begin
      errors++; $display("FAIL mid_flags got busy=%b done=%b pass=%b exp 0/0/0", busy[0], done_v[0], pass_v[0]); end
    checks++; if (a_rx !== 5'd0 || a_err !== 5'd0 || st[0] !== IDLE) begin
      errors++; $display("FAIL mid_status got rx=%0d err=%0d st=%0d exp 0/0/0", a_rx, a_err, st[0]); end
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    rewind_fifo(0);
    pulse_start(0);
    run_until_done(0, 100, 1'b0, 8'hFF, p, d, v);
    checks++; if (pass_v[0] !== 1'b1 || a_rx !== 5'd16) begin
      errors++; $display("FAIL mid_rerun got pass=%b rx=%0d exp 1/16", pass_v[0], a_rx); end
  endtask

  task automatic test_lfsr();
    int p, d, v;
    logic [7:0] e;
    e = 8'h01;
    for (int k = 0; k < 256; k++) begin
      mem[1][k] = e;
      e = {1'b0, e[7:1]} ^ (e[0] ? 8'hB8 : 8'h00);
    end
    len[1] = 256;
    rewind_fifo(1);
    pulse_start(1);
    run_until_done(1, 600, 1'b0, 8'hFF, p, d, v);
    checks++; if (pass_v[1] !== 1'b1) begin errors++; $display("FAIL lfsr_pass got=%b exp=1", pass_v[1]); end
    checks++; if (b_rx !== 9'd256 || b_err !== 9'd0) begin
      errors++; $display("FAIL lfsr_counts got rx=%0d err=%0d exp 256/0", b_rx, b_err); end
  endtask

  task automatic test_wrap();
    int p, d, v;
    load_incr(2, 2, 8'hFF);
    pulse_start(2);
    run_until_done(2, 50, 1'b0, 8'hFF, p, d, v);
    checks++; if (pass_v[2] !== 1'b1 || c_rx !== 2'd2 || c_err !== 2'd0) begin
      errors++; $display("FAIL wrap_pass got pass=%b rx=%0d err=%0d exp 1/2/0", pass_v[2], c_rx, c_err); end
    mem[2][1] = 8'h01;
    rewind_fifo(2);
    pulse_start(2);
    run_until_done(2, 50, 1'b0, 8'hFF, p, d, v);
    checks++; if (c_err !== 2'd1 || c_fidx !== 2'd1 || fexp[2] !== 8'h00 || fgot[2] !== 8'h01) begin
      errors++; $display("FAIL wrap_capture got err=%0d idx=%0d exp=%h got=%h need 1/1/00/01", c_err, c_fidx, fexp[2], fgot[2]); end
    checks++; if (pass_v[2] !== 1'b0) begin errors++; $display("FAIL wrap_fail_pass got=%b exp=0", pass_v[2]); end
  endtask

  task automatic test_throttle();
    int p, d, v;
    load_incr(3, 16, 8'h01);
    pulse_start(3);
    run_until_done(3, 400, 1'b1, 8'h55, p, d, v);
    checks++; if (v != 0)  begin errors++; $display("FAIL thr_gating got=%0d illegal pops exp=0", v); end
    checks++; if (p != 16) begin errors++; $display("FAIL thr_pulses got=%0d exp=16", p); end
    checks++; if (d != 3)  begin errors++; $display("FAIL thr_drain got=%0d exp=3", d); end
    checks++; if (pass_v[3] !== 1'b1 || d_rx !== 5'd16 || d_err !== 5'd0) begin
      errors++; $display("FAIL thr_pass got pass=%b rx=%0d err=%0d exp 1/16/0", pass_v[3], d_rx, d_err); end
  endtask

  initial begin
    rst_l = 1'b0;
    for (int i = 0; i < N; i++) begin
      start[i]  = 1'b0;
      block[i]  = 1'b0;
      rewind[i] = 1'b0;
      len[i]    = 0;
    end
    @(negedge clk);
    test_reset();
    test_basic();
    test_corrupt();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    test_lfsr();
    test_wrap();
    test_throttle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
